// File: rtl/ladybird_inst_sequencer.sv
// ============================================================================
// Module : ladybird_inst_sequencer
// Brief  : Expands queued debug/boot commands (LI, SB, JAL, NOPS) into RV32I
//          instructions on a registered valid/ready injection port.
//          Optional counters enabled by LADYBIRD_INST_SEQUENCER_STATS_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ladybird_inst_sequencer #(
    parameter int CMD_DEPTH = 4,
    parameter int TMP_REG   = 31,
    parameter int NOP_CNT_W = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [4:0]  cmd_rd,
    input  logic [31:0] cmd_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic        busy,
    output logic        err,
    input  logic        err_clr
`ifdef LADYBIRD_INST_SEQUENCER_STATS_EN
    ,
    output logic [31:0] inst_count,
    output logic [31:0] cmd_count
`endif
);

    localparam int               c_PTR_W     = $clog2(CMD_DEPTH);
    localparam logic [c_PTR_W:0] c_PTR_ONE   = {{c_PTR_W{1'b0}}, 1'b1};
    localparam logic [NOP_CNT_W-1:0] c_CNT_ONE = {{(NOP_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [6:0]       c_OP_LUI    = 7'b0110111;
    localparam logic [6:0]       c_OP_IMM    = 7'b0010011;
    localparam logic [6:0]       c_OP_STORE  = 7'b0100011;
    localparam logic [6:0]       c_OP_JAL    = 7'b1101111;
    localparam logic [31:0]      c_NOP       = 32'h0000_0013;
    localparam logic [4:0]       c_TMP       = 5'(TMP_REG);
    localparam logic [1:0]       c_CMD_LI    = 2'd0;
    localparam logic [1:0]       c_CMD_SB    = 2'd1;
    localparam logic [1:0]       c_CMD_JAL   = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_EMIT_HI  = 2'd1,
        S_EMIT_LO  = 2'd2,
        S_EMIT_NOP = 2'd3
    } state_t;

    // ---------------- command FIFO ----------------
    logic [38:0]        r_fifo [CMD_DEPTH];
    logic [c_PTR_W:0]   r_wr_ptr;
    logic [c_PTR_W:0]   r_rd_ptr;
    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                       (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
    assign w_push    = cmd_valid && !w_full;
    assign cmd_ready = !w_full;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr[c_PTR_W-1:0]] <= {cmd_op, cmd_rd, cmd_data};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
        end
    end

    // ---------------- head decode ----------------
    logic [38:0]  w_head;
    logic [1:0]   w_h_op;
    logic [4:0]   w_h_rd;
    logic [31:0]  w_h_data;
    logic [19:0]  w_hi;
    logic [11:0]  w_lo;

    assign w_head   = r_fifo[r_rd_ptr[c_PTR_W-1:0]];
    assign w_h_op   = w_head[38:37];
    assign w_h_rd   = w_head[36:32];
    assign w_h_data = w_head[31:0];
    // Rounded upper part so that the sign-extended low 12 bits add back exactly.
    assign w_hi     = w_h_data[31:12] + 20'(w_h_data[11]);
    assign w_lo     = w_h_data[11:0];

    logic               w_illegal;
    state_t             w_first_state;
    logic [31:0]        w_dec_hi;
    logic [31:0]        w_dec_lo;
    logic [NOP_CNT_W-1:0] w_dec_cnt;

    always_comb begin
        w_illegal     = 1'b0;
        w_first_state = S_EMIT_LO;
        w_dec_hi      = c_NOP;
        w_dec_lo      = c_NOP;
        w_dec_cnt     = '0;
        case (w_h_op)
            c_CMD_LI: begin
                if (w_h_rd == 5'd0) begin
                    w_first_state = S_EMIT_NOP;
                end else if (w_hi == 20'd0) begin
                    w_dec_lo = {w_lo, 5'd0, 3'b000, w_h_rd, c_OP_IMM};
                end else if (w_lo == 12'd0) begin
                    w_dec_lo = {w_hi, w_h_rd, c_OP_LUI};
                end else begin
                    w_first_state = S_EMIT_HI;
                    w_dec_hi      = {w_hi, w_h_rd, c_OP_LUI};
                    w_dec_lo      = {w_lo, w_h_rd, 3'b000, w_h_rd, c_OP_IMM};
                end
            end
            c_CMD_SB: begin
                if (w_hi == 20'd0) begin
                    w_dec_lo = {w_lo[11:5], w_h_rd, 5'd0, 3'b000, w_lo[4:0], c_OP_STORE};
                end else if (w_h_rd == c_TMP) begin
                    w_illegal = 1'b1;
                end else begin
                    w_first_state = S_EMIT_HI;
                    w_dec_hi      = {w_hi, c_TMP, c_OP_LUI};
                    w_dec_lo      = {w_lo[11:5], w_h_rd, c_TMP, 3'b000, w_lo[4:0], c_OP_STORE};
                end
            end
            c_CMD_JAL: begin
                if (w_h_data[0] || (w_h_data[31:21] != {11{w_h_data[20]}})) begin
                    w_illegal = 1'b1;
                end
                w_dec_lo = {w_h_data[20], w_h_data[10:1], w_h_data[11],
                            w_h_data[19:12], w_h_rd, c_OP_JAL};
            end
            default: begin
                w_first_state = S_EMIT_NOP;
                w_dec_cnt     = w_h_data[NOP_CNT_W-1:0];
            end
        endcase
    end

    // ---------------- sequencer FSM ----------------
    state_t               r_state;
    state_t               w_state_nxt;
    logic [31:0]          r_hi_inst;
    logic [31:0]          r_lo_inst;
    logic [NOP_CNT_W-1:0] r_nop_cnt;
    logic                 r_inst_valid;
    logic [31:0]          r_inst;
    logic                 r_err;
    logic                 w_out_free;
    logic                 w_ld;
    logic [31:0]          w_ld_inst;
    logic                 w_set_err;
    logic                 w_cnt_dec;

    assign w_out_free = !r_inst_valid || inst_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_ld        = 1'b0;
        w_ld_inst   = c_NOP;
        w_set_err   = 1'b0;
        w_cnt_dec   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (w_illegal) w_set_err   = 1'b1;
                    else           w_state_nxt = w_first_state;
                end
            end
            S_EMIT_HI: begin
                if (w_out_free) begin
                    w_ld        = 1'b1;
                    w_ld_inst   = r_hi_inst;
                    w_state_nxt = S_EMIT_LO;
                end
            end
            S_EMIT_LO: begin
                if (w_out_free) begin
                    w_ld        = 1'b1;
                    w_ld_inst   = r_lo_inst;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                if (w_out_free) begin
                    w_ld = 1'b1;
                    if (r_nop_cnt == '0) w_state_nxt = S_IDLE;
                    else                 w_cnt_dec   = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_hi_inst <= c_NOP;
            r_lo_inst <= c_NOP;
            r_nop_cnt <= '0;
        end else if (w_pop) begin
            r_hi_inst <= w_dec_hi;
            r_lo_inst <= w_dec_lo;
            r_nop_cnt <= w_dec_cnt;
        end else if (w_cnt_dec) begin
            r_nop_cnt <= r_nop_cnt - c_CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_inst_valid <= 1'b0;
            r_inst       <= c_NOP;
        end else if (w_ld) begin
            r_inst_valid <= 1'b1;
            r_inst       <= w_ld_inst;
        end else if (inst_ready) begin
            r_inst_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)          r_err <= 1'b0;
        else if (w_set_err) r_err <= 1'b1;
        else if (err_clr)   r_err <= 1'b0;
    end

    assign inst_valid = r_inst_valid;
    assign inst       = r_inst;
    assign err        = r_err;
    assign busy       = !w_empty || (r_state != S_IDLE) || r_inst_valid;

`ifdef LADYBIRD_INST_SEQUENCER_STATS_EN
    logic [31:0] r_inst_count;
    logic [31:0] r_cmd_count;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_inst_count <= '0;
            r_cmd_count  <= '0;
        end else begin
            if (r_inst_valid && inst_ready) r_inst_count <= r_inst_count + 32'd1;
            if (w_pop)                      r_cmd_count  <= r_cmd_count + 32'd1;
        end
    end

    assign inst_count = r_inst_count;
    assign cmd_count  = r_cmd_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ladybird_inst_sequencer.sv
// ============================================================================
// Module : tb_ladybird_inst_sequencer
// Brief  : Scoreboard bench for ladybird_inst_sequencer with directed commands.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ladybird_inst_sequencer;

    localparam int          CMD_DEPTH = 4;
    localparam logic [31:0] c_NOP     = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_rd;
    logic [31:0] cmd_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic        busy;
    logic        err;
    logic        err_clr;
`ifdef LADYBIRD_INST_SEQUENCER_STATS_EN
    logic [31:0] inst_count;
    logic [31:0] cmd_count;
`endif

    ladybird_inst_sequencer #(
        .CMD_DEPTH (CMD_DEPTH),
        .TMP_REG   (31),
        .NOP_CNT_W (4)
    ) u_dut (
        .clk        (clk),
        .rstn       (rstn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_rd     (cmd_rd),
        .cmd_data   (cmd_data),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .busy       (busy),
        .err        (err),
        .err_clr    (err_clr)
`ifdef LADYBIRD_INST_SEQUENCER_STATS_EN
        ,
        .inst_count (inst_count),
        .cmd_count  (cmd_count)
`endif
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: handshake at the next rising edge is decided by the values seen here.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_inst  = '0;
    always @(negedge clk) begin
        if (!rstn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("valid_hold", {31'd0, inst_valid}, 32'd1);
                check("inst_hold", inst, prev_inst);
            end
            if (inst_valid && inst_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_inst: got %h, expected none", inst);
                end else begin
                    check("inst_stream", inst, exp_q.pop_front());
                end
            end
            prev_stall = inst_valid && !inst_ready;
            prev_inst  = inst;
        end
    end

    task automatic push(input logic [1:0] op, input logic [4:0] rd, input logic [31:0] d);
        int n = 0;
        cmd_op    = op;
        cmd_rd    = rd;
        cmd_data  = d;
        cmd_valid = 1'b1;
        while (!cmd_ready) begin
            if (n >= 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL push_timeout: got cmd_ready=0, expected 1");
                break;
            end
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 || busy) begin
            if (n >= 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s_timeout: got %0d pending, expected 0", name, exp_q.size());
                exp_q.delete();
                break;
            end
            @(posedge clk); #1;
            n++;
        end
    endtask

    logic [31:0] fill_exp [6] = '{32'h00100093, 32'h00200113, 32'h00300193,
                                  32'h00400213, 32'h00500293, 32'h00600313};

    initial begin
        rstn       = 1'b0;
        cmd_valid  = 1'b0;
        cmd_op     = 2'd0;
        cmd_rd     = 5'd0;
        cmd_data   = 32'd0;
        inst_ready = 1'b1;
        err_clr    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_inst", inst, c_NOP);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);
        rstn = 1'b1;
        @(posedge clk); #1;

        // LI split across LUI/ADDI, with latency and busy checks
        exp_q.push_back(32'h123462B7);
        exp_q.push_back(32'hFFF28293);
        push(2'd0, 5'd5, 32'h12345FFF);
        check("lat_k", {31'd0, inst_valid}, 32'd0);
        @(posedge clk); #1;
        check("lat_k1", {31'd0, inst_valid}, 32'd0);
        @(posedge clk); #1;
        check("lat_k2", {31'd0, inst_valid}, 32'd1);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check("busy_after_li", {31'd0, busy}, 32'd0);

        exp_q.push_back(32'h000012B7);
        exp_q.push_back(32'h80028293);
        push(2'd0, 5'd5, 32'h00000800);
        exp_q.push_back(32'h7FF00293);
        push(2'd0, 5'd5, 32'h000007FF);
        exp_q.push_back(c_NOP);
        push(2'd0, 5'd0, 32'h12345678);
        drain("li");

        // Stores: direct, via scratch register, and illegal
        exp_q.push_back(32'h10500023);
        push(2'd1, 5'd5, 32'h00000100);
        exp_q.push_back(32'h00012FB7);
        exp_q.push_back(32'h345F82A3);
        push(2'd1, 5'd5, 32'h00012345);
        drain("sb");
        check("err_before_illegal", {31'd0, err}, 32'd0);
        push(2'd1, 5'd31, 32'h00010000);
        drain("sb_illegal");
        check("err_sb_illegal", {31'd0, err}, 32'd1);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        check("err_cleared", {31'd0, err}, 32'd0);

        // JAL forward/backward, misaligned JAL followed by queued NOPS
        exp_q.push_back(32'h008000EF);
        push(2'd2, 5'd1, 32'h00000008);
        exp_q.push_back(32'hFFDFF06F);
        push(2'd2, 5'd0, 32'hFFFFFFFC);
        drain("jal");
        check("err_jal_ok", {31'd0, err}, 32'd0);
        exp_q.push_back(c_NOP);
        exp_q.push_back(c_NOP);
        exp_q.push_back(c_NOP);
        push(2'd2, 5'd1, 32'h00000003);
        push(2'd3, 5'd0, 32'h00000002);
        drain("nops");
        check("err_jal_bad", {31'd0, err}, 32'd1);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;

        // Back-pressure: fill the FIFO while output stalls
        inst_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(fill_exp[i]);
            push(2'd0, 5'(i + 1), 32'(i + 1));
        end
        check("full_ready", {31'd0, cmd_ready}, 32'd0);
        cmd_op    = 2'd3;
        cmd_rd    = 5'd0;
        cmd_data  = 32'd5;
        cmd_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("full_ready_held", {31'd0, cmd_ready}, 32'd0);
        cmd_valid = 1'b0;
        check("stall_inst", inst, 32'h00100093);
        inst_ready = 1'b1;
        drain("fill");

        // Reset in the middle of a LUI/ADDI pair
        inst_ready = 1'b0;
        exp_q.push_back(32'h123462B7);
        exp_q.push_back(32'hFFF28293);
        push(2'd0, 5'd5, 32'h12345FFF);
        for (int i = 0; i < 10 && !inst_valid; i++) begin
            @(posedge clk); #1;
        end
        check("mid_lui", inst, 32'h123462B7);
        #2;
        rstn = 1'b0;
        #1;
        exp_q.delete();
        check("mid_rst_valid", {31'd0, inst_valid}, 32'd0);
        check("mid_rst_inst", inst, c_NOP);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
`ifdef LADYBIRD_INST_SEQUENCER_STATS_EN
        check("rst_inst_count", inst_count, 32'd0);
        check("rst_cmd_count", cmd_count, 32'd0);
`endif
        @(posedge clk); #1;
        rstn       = 1'b1;
        inst_ready = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back(32'h00001337);
        push(2'd0, 5'd6, 32'h00001000);
        drain("post_rst");
`ifdef LADYBIRD_INST_SEQUENCER_STATS_EN
        check("post_inst_count", inst_count, 32'd1);
        check("post_cmd_count", cmd_count, 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
